// File: rtl/rom_mult_pkg.sv
// Shared widths and the ROM content function for the 4x4 lookup multiplier.
package rom_mult_pkg;

  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam int ADDR_W    = 2 * OP_W;
  localparam int ROM_DEPTH = 2 ** ADDR_W;

  // Table entry for address a: upper operand nibble times lower operand nibble.
  // Only ever evaluated on constants, so it folds into the table rather than a multiplier.
  function automatic logic [PROD_W-1:0] rom_entry(input logic [ADDR_W-1:0] a);
    return PROD_W'(a[ADDR_W-1:OP_W]) * PROD_W'(a[OP_W-1:0]);
  endfunction

endpackage

// File: rtl/rom_mult_rom.sv
// 256x8 constant product table with a one-clock registered read.
module mult_rom
  import rom_mult_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [PROD_W-1:0] dout
);

  logic [PROD_W-1:0] rom_tbl [ROM_DEPTH];
  logic [PROD_W-1:0] dout_q;

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_tbl
    assign rom_tbl[g] = rom_entry(ADDR_W'(g));
  end

  // Synchronous read; no reset on the data path so it maps onto block or distributed ROM.
  always_ff @(posedge clk) begin
    dout_q <= rom_tbl[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/rom_mult.sv
// Request/ready shell around the product ROM: async clear, hold-on-idle, 1-cycle latency.
module rom_mult
  import rom_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,   // active-high despite the name
  input  logic              en,
  input  logic [OP_W-1:0]   mult1,
  input  logic [OP_W-1:0]   mult2,
  output logic [PROD_W-1:0] dat,
  output logic              rdy
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rdy_q;
  logic              seen_q;   // a product has been sampled since reset
  logic [PROD_W-1:0] rom_dout;

  // Idle cycles re-read the last sampled address so the ROM output holds.
  always_comb begin
    addr_d = addr_q;
    if (en) addr_d = {mult1, mult2};
  end

  // Shell state: last address, ready flag, and the post-reset gate for dat.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_q <= '0;
      rdy_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rdy_q  <= en;
      if (en) seen_q <= 1'b1;
    end
  end

  mult_rom u_rom (
    .clk  (clk),
    .addr (addr_d),
    .dout (rom_dout)
  );

  // Reset-gated output: clears the instant reset rises, stays zero until a fresh request.
  assign dat = seen_q ? rom_dout : '0;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_rom_mult.sv
// Directed bench for rom_mult: reset, sequences, corners, idle hold, async reset, full sweep.
module tb_rom_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] mult1, mult2;
  logic [7:0] dat;
  logic       rdy;

  int total = 0;
  int fails = 0;

  rom_mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mult1 (mult1),
    .mult2 (mult2),
    .dat   (dat),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp;
    rst_n = 1'b1; en = 1'b0; mult1 = 4'd0; mult2 = 4'd0;

    // 1. reset held 50 ns, then released with en=0
    #3;
    chk("rst_dat", dat, 8'd0);
    chk("rst_rdy", {7'd0, rdy}, 8'd0);
    #30;
    mult1 = 4'd7; mult2 = 4'd7;
    chk("rst_dat_hold", dat, 8'd0);
    chk("rst_rdy_hold", {7'd0, rdy}, 8'd0);
    #17;
    rst_n = 1'b0;
    tick(); tick();
    chk("post_rst_dat", dat, 8'd0);
    chk("post_rst_rdy", {7'd0, rdy}, 8'd0);

    // 2. single request
    en = 1'b1; mult1 = 4'd5; mult2 = 4'd5;
    tick();
    chk("5x5_dat", dat, 8'd25);
    chk("5x5_rdy", {7'd0, rdy}, 8'd1);

    // 3. back-to-back 10 * 5..10
    mult1 = 4'd10;
    for (int k = 5; k <= 10; k++) begin
      mult2 = 4'(k);
      tick();
      chk("10xk_dat", dat, 8'(10 * k));
      chk("10xk_rdy", {7'd0, rdy}, 8'd1);
    end

    // 4. 3 * 0..5 then corners
    mult1 = 4'd3;
    for (int k = 0; k <= 5; k++) begin
      mult2 = 4'(k);
      tick();
      chk("3xk_dat", dat, 8'(3 * k));
    end
    mult1 = 4'd15; mult2 = 4'd15; tick(); chk("15x15", dat, 8'd225);
    mult1 = 4'd0;  mult2 = 4'd15; tick(); chk("0x15",  dat, 8'd0);
    mult1 = 4'd15; mult2 = 4'd1;  tick(); chk("15x1",  dat, 8'd15);
    mult1 = 4'd12; mult2 = 4'd11; tick(); chk("12x11", dat, 8'd132);

    // 5. drop en: rdy falls, dat holds through operand changes
    en = 1'b0; mult1 = 4'd2; mult2 = 4'd2;
    tick();
    chk("idle_rdy", {7'd0, rdy}, 8'd0);
    chk("idle_dat", dat, 8'd132);
    mult1 = 4'd9; mult2 = 4'd14;
    tick(); tick();
    chk("idle_dat_hold", dat, 8'd132);
    chk("idle_rdy_hold", {7'd0, rdy}, 8'd0);

    // 6. async reset mid-stream
    en = 1'b1; mult1 = 4'd6; mult2 = 4'd7;
    tick();
    chk("pre_arst_dat", dat, 8'd42);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_dat", dat, 8'd0);
    chk("arst_rdy", {7'd0, rdy}, 8'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("arst_rel_dat", dat, 8'd0);
    chk("arst_rel_rdy", {7'd0, rdy}, 8'd0);
    en = 1'b1; mult1 = 4'd13; mult2 = 4'd4;
    tick();
    chk("post_arst_dat", dat, 8'd52);
    chk("post_arst_rdy", {7'd0, rdy}, 8'd1);

    // exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        mult1 = 4'(i); mult2 = 4'(j);
        tick();
        exp = 8'(i * j);
        chk("sweep", dat, exp);
      end
    end
    en = 1'b0;
    tick();
    chk("end_rdy", {7'd0, rdy}, 8'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
